// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared encodings for the button event scheduler
// Contents:
//   evt_kind_e  - event kind carried on the event channel
//   btn_state_e - per-button hold/repeat state
package pong_pkg;

    typedef enum logic [1:0] {
        KIND_NONE    = 2'b00,
        KIND_PRESS   = 2'b01,
        KIND_RELEASE = 2'b10,
        KIND_REPEAT  = 2'b11
    } evt_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_REPEAT = 2'b10
    } btn_state_e;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing a one-cycle tick
// Ports:
//   clock - system clock
//   reset - asynchronous active-high reset
//   tick  - high for one cycle when the counter sits at TICK_DIV-1
module tick_gen #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/btn_event_sched.sv
// rtl/btn_event_sched.sv - press/release/repeat event generator with round-robin output channel
// Ports:
//   clock, reset       - system clock, asynchronous active-high reset
//   db[N_BTN]          - debounced button levels
//   evt_valid/evt_ready- event channel handshake
//   evt_id             - button index of the held event
//   evt_kind           - 01 press, 10 release, 11 repeat
//   ovf                - sticky: an event was lost
module btn_event_sched #(
    parameter int N_BTN        = 4,
    parameter int TICK_DIV     = 1000000,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_BTN-1:0]         db,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [$clog2(N_BTN)-1:0] evt_id,
    output logic [1:0]               evt_kind,
    output logic                     ovf
);

    import pong_pkg::*;

    localparam int IDW  = $clog2(N_BTN);
    localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNTW = $clog2(CMAX + 1);
    localparam logic [CNTW-1:0] DELAY_LAST = CNTW'(REPEAT_DELAY - 1);
    localparam logic [CNTW-1:0] RATE_LAST  = CNTW'(REPEAT_RATE - 1);

    logic                tick;
    btn_state_e          state_q [N_BTN];
    logic [CNTW-1:0]     cnt_q   [N_BTN];
    logic [N_BTN-1:0]    db_q;
    logic [N_BTN-1:0]    press_q, rel_q, rep_q;
    logic [N_BTN-1:0]    press_d, rel_d, rep_d;
    logic                primed_q;
    logic [IDW-1:0]      rr_q;
    logic                evt_valid_q;
    logic [IDW-1:0]      evt_id_q;
    evt_kind_e           evt_kind_q;
    logic                ovf_q;

    logic [N_BTN-1:0]    rise, fall, fire, pend_any;
    logic [N_BTN-1:0]    clr_press, clr_rel, clr_rep;
    logic                load, grant_valid, ovf_hit;
    logic [IDW-1:0]      grant_id;
    evt_kind_e           grant_kind;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Edges are ignored on the first cycle after reset so that buttons already
    // held at reset release are absorbed into db_q silently. A fall only counts
    // for a button whose press was seen, so such a button stays quiet until it
    // is released and pressed again.
    always_comb begin
        rise = '0;
        fall = '0;
        fire = '0;
        for (int i = 0; i < N_BTN; i++) begin
            rise[i] = primed_q & db[i] & ~db_q[i];
            fall[i] = primed_q & ~db[i] & db_q[i] & (state_q[i] != ST_IDLE);
            fire[i] = tick & ~fall[i] &
                      (((state_q[i] == ST_DELAY)  && (cnt_q[i] == DELAY_LAST)) ||
                       ((state_q[i] == ST_REPEAT) && (cnt_q[i] == RATE_LAST)));
        end
    end

    assign pend_any = press_q | rel_q | rep_q;
    assign load     = ~evt_valid_q | evt_ready;

    // Round-robin search starting one past the last granted button.
    always_comb begin
        int             j;
        logic [IDW-1:0] cand;
        j           = 0;
        cand        = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        grant_kind  = KIND_NONE;
        clr_press   = '0;
        clr_rel     = '0;
        clr_rep     = '0;
        for (int off = 1; off <= N_BTN; off++) begin
            j = int'(rr_q) + off;
            if (j >= N_BTN) begin
                j = j - N_BTN;
            end
            cand = IDW'(j);
            if (!grant_valid && pend_any[cand]) begin
                grant_valid = 1'b1;
                grant_id    = cand;
            end
        end
        if (grant_valid) begin
            if (press_q[grant_id]) begin
                grant_kind          = KIND_PRESS;
                clr_press[grant_id] = load;
            end else if (rel_q[grant_id]) begin
                grant_kind        = KIND_RELEASE;
                clr_rel[grant_id] = load;
            end else begin
                grant_kind        = KIND_REPEAT;
                clr_rep[grant_id] = load;
            end
        end
    end

    // A fall discards any queued repeat; that discard is not a loss.
    assign press_d = (press_q & ~clr_press) | rise;
    assign rel_d   = (rel_q & ~clr_rel) | fall;
    assign rep_d   = (rep_q & ~clr_rep & ~fall) | fire;
    assign ovf_hit = |((rise & press_q & ~clr_press) |
                       (fall & rel_q   & ~clr_rel)   |
                       (fire & rep_q   & ~clr_rep));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_q        <= '0;
            press_q     <= '0;
            rel_q       <= '0;
            rep_q       <= '0;
            primed_q    <= 1'b0;
            rr_q        <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_kind_q  <= KIND_NONE;
            ovf_q       <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            primed_q <= 1'b1;
            db_q     <= db;
            press_q  <= press_d;
            rel_q    <= rel_d;
            rep_q    <= rep_d;
            ovf_q    <= ovf_q | ovf_hit;
            if (load) begin
                evt_valid_q <= grant_valid;
                if (grant_valid) begin
                    evt_id_q   <= grant_id;
                    evt_kind_q <= grant_kind;
                    rr_q       <= grant_id;
                end
            end
            for (int i = 0; i < N_BTN; i++) begin
                if (fall[i]) begin
                    state_q[i] <= ST_IDLE;
                    cnt_q[i]   <= '0;
                end else if (rise[i]) begin
                    state_q[i] <= ST_DELAY;
                    cnt_q[i]   <= '0;
                end else if (tick && (state_q[i] != ST_IDLE)) begin
                    if (fire[i]) begin
                        state_q[i] <= ST_REPEAT;
                        cnt_q[i]   <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CNTW'(1);
                    end
                end
            end
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_kind  = evt_kind_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_btn_event_sched.sv
// tb/tb_btn_event_sched.sv - directed self-checking bench for btn_event_sched
module tb_btn_event_sched;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] db;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic [1:0] evt_kind;
    logic       ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int m, f, g;

    int log_cyc[$];
    int log_id[$];
    int log_kind[$];

    btn_event_sched #(
        .N_BTN(4), .TICK_DIV(4), .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .db        (db),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_kind  (evt_kind),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset && evt_valid && evt_ready) begin
            log_cyc.push_back(cyc);
            log_id.push_back(int'(evt_id));
            log_kind.push_back(int'(evt_kind));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lc(input int i);
        return (i < log_cyc.size()) ? log_cyc[i] : -1000;
    endfunction
    function automatic int li(input int i);
        return (i < log_id.size()) ? log_id[i] : -1;
    endfunction
    function automatic int lk(input int i);
        return (i < log_kind.size()) ? log_kind[i] : -1;
    endfunction

    task automatic clear_log();
        log_cyc.delete();
        log_id.delete();
        log_kind.delete();
    endtask

    initial begin
        reset = 1'b1;
        db = 4'b0000;
        evt_ready = 1'b0;
        step(3);
        check("reset_valid", int'(evt_valid), 0);
        check("reset_id",    int'(evt_id),    0);
        check("reset_kind",  int'(evt_kind),  0);
        check("reset_ovf",   int'(ovf),       0);
        reset = 1'b0;
        step(2);

        // single press: valid two edges after the change, for one cycle
        evt_ready = 1'b1;
        clear_log();
        m = cyc;
        db[2] = 1'b1;
        step(1);
        check("press_not_early", int'(evt_valid), 0);
        step(1);
        check("press_valid", int'(evt_valid), 1);
        check("press_id",    int'(evt_id),    2);
        check("press_kind",  int'(evt_kind),  1);
        step(1);
        check("press_one_cycle", int'(evt_valid), 0);
        db[2] = 1'b0;
        step(4);
        check("single_log_n",  log_cyc.size(), 2);
        check("single_lat",    lc(0) - m, 2);
        check("single_rel_id", li(1), 2);
        check("single_rel_k",  lk(1), 2);

        // hold with auto-repeat
        clear_log();
        m = cyc;
        db[1] = 1'b1;
        step(30);
        f = cyc;
        db[1] = 1'b0;
        step(6);
        check("hold_log_n", log_cyc.size(), 5);
        check("hold_press_lat", lc(0) - m, 2);
        check("hold_k0", lk(0), 1);
        check("hold_k1", lk(1), 3);
        check("hold_k2", lk(2), 3);
        check("hold_k3", lk(3), 3);
        check("hold_k4", lk(4), 2);
        for (int i = 0; i < 5; i++) check("hold_id", li(i), 1);
        g = lc(1) - lc(0);
        check("hold_first_rep_window", int'(g >= 8 && g <= 16), 1);
        check("hold_rep_gap1", lc(2) - lc(1), 8);
        check("hold_rep_gap2", lc(3) - lc(2), 8);
        check("hold_rel_lat", lc(4) - f, 2);

        // make id 3 the last grant, then three simultaneous presses/releases
        db[3] = 1'b1;
        step(4);
        db[3] = 1'b0;
        step(4);
        clear_log();
        m = cyc;
        db = 4'b1011;
        step(6);
        db = 4'b0000;
        step(8);
        check("rr_log_n", log_cyc.size(), 6);
        check("rr_id0", li(0), 0);
        check("rr_id1", li(1), 1);
        check("rr_id2", li(2), 3);
        check("rr_id3", li(3), 0);
        check("rr_id4", li(4), 1);
        check("rr_id5", li(5), 3);
        check("rr_k0", lk(0), 1);
        check("rr_k3", lk(3), 2);
        check("rr_c0", lc(0) - m, 2);
        check("rr_c1", lc(1) - m, 3);
        check("rr_c2", lc(2) - m, 4);
        check("rr_c3", lc(3) - m, 8);
        check("rr_c5", lc(5) - m, 10);

        // back-pressure: held press, queued release, no loss
        evt_ready = 1'b0;
        clear_log();
        db[2] = 1'b1;
        step(3);
        db[2] = 1'b0;
        step(3);
        check("bp_valid", int'(evt_valid), 1);
        check("bp_id",    int'(evt_id),    2);
        check("bp_kind",  int'(evt_kind),  1);
        step(2);
        check("bp_stable_kind", int'(evt_kind), 1);
        check("bp_stable_id",   int'(evt_id),   2);
        check("bp_ovf",         int'(ovf),      0);
        evt_ready = 1'b1;
        step(1);
        check("bp_rel_valid", int'(evt_valid), 1);
        check("bp_rel_kind",  int'(evt_kind),  2);
        step(1);
        check("bp_drain", int'(evt_valid), 0);
        check("bp_log_n", log_cyc.size(), 2);
        check("bp_log_k0", lk(0), 1);
        check("bp_log_k1", lk(1), 2);
        check("bp_ovf_end", int'(ovf), 0);

        // overflow: second press while first still pending behind a busy channel
        evt_ready = 1'b0;
        db[3] = 1'b1;
        step(3);
        db[2] = 1'b1;
        step(1);
        db[2] = 1'b0;
        step(1);
        check("ovf_not_yet", int'(ovf), 0);
        db[2] = 1'b1;
        step(1);
        check("ovf_set", int'(ovf), 1);
        step(3);
        check("ovf_sticky", int'(ovf), 1);
        check("ovf_held_id",   int'(evt_id),   3);
        check("ovf_held_kind", int'(evt_kind), 1);
        reset = 1'b1;
        #1;
        check("rst_async_valid", int'(evt_valid), 0);
        step(1);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_ovf",   int'(ovf),       0);
        evt_ready = 1'b1;
        clear_log();
        reset = 1'b0;
        step(6);
        check("held_at_release_quiet", log_cyc.size(), 0);
        db = 4'b0000;
        step(4);
        check("held_fall_quiet", log_cyc.size(), 0);
        db[2] = 1'b1;
        step(3);
        check("repress_n",  log_cyc.size(), 1);
        check("repress_id", li(0), 2);
        check("repress_k",  lk(0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
